// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encoding and the buffered result record.
// Optional parity storage in the buffer is enabled by defining ALU_RES_PARITY_EN.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 4;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_MUL  = 4'b0010,
    ALU_DIV  = 4'b0011,
    ALU_SHL  = 4'b0100,
    ALU_SHR  = 4'b0101,
    ALU_ROL  = 4'b0110,
    ALU_ROR  = 4'b0111,
    ALU_AND  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_NOR  = 4'b1011,
    ALU_NAND = 4'b1100,
    ALU_XNOR = 4'b1101,
    ALU_GT   = 4'b1110,
    ALU_EQ   = 4'b1111
  } alu_op_e;

  // Field order matches the packed entry layout used in the buffer: {sel, carry, data}.
  typedef struct packed {
    logic [ALU_SEL_W-1:0] sel;
    logic                 carry;
    logic [ALU_WIDTH-1:0] data;
  } alu_res_t;

endpackage

// File: rtl/alu_res_mem.sv
// Result storage: DEPTH entries, one synchronous write port, one asynchronous read port.
// Storage is deliberately not reset; validity is tracked by the buffer's level counter.
module alu_res_mem
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = $bits(alu_res_t),
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write the pushed entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO between the combinational ALU and a slower consumer, with zero flag and a
// saturating count of accepted results. Defining ALU_RES_PARITY_EN adds a per-entry
// even-parity bit plus out_par_err / par_err_sticky outputs.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_carry,
  input  logic [SEL_W-1:0]           in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       out_zero,
`ifdef ALU_RES_PARITY_EN
  output logic                       out_par_err,
  output logic                       par_err_sticky,
`endif
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           result_cnt
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH+1);
  localparam int REC_W = SEL_W + 1 + WIDTH;
`ifdef ALU_RES_PARITY_EN
  localparam int EW = REC_W + 1;
`else
  localparam int EW = REC_W;
`endif
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;
  logic [REC_W-1:0] in_rec, head_rec;
  logic [EW-1:0]    wr_entry, rd_entry;

  assign in_ready  = (level != FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_rec    = {in_sel, in_carry, in_data};

`ifdef ALU_RES_PARITY_EN
  // Stored bit makes the whole entry even parity; a mismatch on read flags corruption.
  assign wr_entry    = {^in_rec, in_rec};
  assign out_par_err = out_valid && ((^rd_entry[REC_W-1:0]) != rd_entry[REC_W]);
`else
  assign wr_entry = in_rec;
`endif
  assign head_rec = rd_entry[REC_W-1:0];

  alu_res_mem #(
    .DEPTH  (DEPTH),
    .ENTRY_W(EW),
    .AW     (PW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .raddr(rd_ptr),
    .rdata(rd_entry)
  );

  // Head fields are masked while empty so stale storage never leaks out.
  always_comb begin
    out_data  = '0;
    out_carry = 1'b0;
    out_sel   = '0;
    if (out_valid) begin
      {out_sel, out_carry, out_data} = head_rec;
    end
  end

  assign out_zero = out_valid && (out_data == '0);

  // Pointers wrap naturally; level alone distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Accepted-result counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (push && (result_cnt != '1)) begin
      result_cnt <= result_cnt + 1'b1;
    end
  end

`ifdef ALU_RES_PARITY_EN
  // Latch any parity error seen on an entry as it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_sticky <= 1'b0;
    end else if (pop && out_par_err) begin
      par_err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: reset, single result, fill/overflow, concurrent
// push/pop with zero flag, pointer wrap, and asynchronous reset mid-operation.
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_carry;
  logic [3:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_carry;
  logic [3:0]  out_sel;
  logic        out_zero;
  logic [2:0]  level;
  logic [15:0] result_cnt;
`ifdef ALU_RES_PARITY_EN
  logic        out_par_err;
  logic        par_err_sticky;
`endif

  int total  = 0;
  int passed = 0;

  alu_result_buffer #(
    .WIDTH(8), .SEL_W(4), .DEPTH(4), .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_carry  (in_carry),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_sel   (out_sel),
    .out_zero  (out_zero),
`ifdef ALU_RES_PARITY_EN
    .out_par_err   (out_par_err),
    .par_err_sticky(par_err_sticky),
`endif
    .level     (level),
    .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_carry  = 1'b0;
    in_sel    = 4'h0;
    out_ready = 1'b0;

    // Reset then idle
    repeat (3) step();
    check("rst_in_ready",  32'(in_ready),   32'd1);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_level",     32'(level),      32'd0);
    check("rst_cnt",       32'(result_cnt), 32'd0);
    check("rst_out_data",  32'(out_data),   32'd0);
    check("rst_out_zero",  32'(out_zero),   32'd0);
    rst_n = 1'b1;
    step();
    check("idle_level", 32'(level), 32'd0);

    // Single result
    in_valid = 1'b1; in_data = 8'hA5; in_carry = 1'b1; in_sel = ALU_NOR;
    step();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'hA5);
    check("single_carry", 32'(out_carry), 32'd1);
    check("single_sel",   32'(out_sel),   32'hB);
    check("single_zero",  32'(out_zero),  32'd0);
    check("single_level", 32'(level),     32'd1);
`ifdef ALU_RES_PARITY_EN
    check("single_par_err", 32'(out_par_err), 32'd0);
`endif
    step();
    check("single_hold_data", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_level", 32'(level),     32'd0);
    check("single_pop_valid", 32'(out_valid), 32'd0);
    check("single_pop_data",  32'(out_data),  32'd0);
    check("single_pop_carry", 32'(out_carry), 32'd0);

    // Fill / overflow: 01..05 back-to-back with consumer stalled
    in_carry = 1'b0; in_sel = ALU_ADD;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      if (i == 4) check("fill_in_ready_full", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("fill_level", 32'(level),      32'd4);
    check("fill_cnt",   32'(result_cnt), 32'd5);
    check("fill_head",  32'(out_data),   32'h01);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_data_%0d", k), 32'(out_data), 32'(k));
      step();
      if (k == 1) check("drain_in_ready_back", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    check("drain_empty_valid", 32'(out_valid), 32'd0);
    check("drain_empty_level", 32'(level),     32'd0);

    // Concurrent push/pop at level 2, zero flag ignores carry
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    check("conc_level_pre", 32'(level), 32'd2);
    in_data = 8'h00; in_carry = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_carry = 1'b0;
    check("conc_level_same", 32'(level),    32'd2);
    check("conc_head",       32'(out_data), 32'h22);
    check("conc_zero_nz",    32'(out_zero), 32'd0);
    step();
    check("zero_head_data",  32'(out_data),  32'h00);
    check("zero_head_carry", 32'(out_carry), 32'd1);
    check("zero_flag",       32'(out_zero),  32'd1);
    check("zero_level",      32'(level),     32'd1);
    step();
    out_ready = 1'b0;
    check("conc_empty", 32'(level), 32'd0);
    check("conc_cnt",   32'(result_cnt), 32'd8);

    // Wrap: 10 results streamed with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i * 3); in_carry = 1'(i); in_sel = 4'(i);
      if (i > 0) check($sformatf("wrap_data_%0d", i - 1), 32'(out_data), 32'((i - 1) * 3));
      step();
      check($sformatf("wrap_level_%0d", i), 32'(level), 32'd1);
    end
    in_valid = 1'b0;
    check("wrap_last_data",  32'(out_data),  32'd27);
    check("wrap_last_carry", 32'(out_carry), 32'd1);
    check("wrap_last_sel",   32'(out_sel),   32'd9);
    check("wrap_cnt",        32'(result_cnt), 32'd18);
    step();
    out_ready = 1'b0;
    check("wrap_empty", 32'(out_valid), 32'd0);

    // Reset mid-operation at level 3
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h40 + 8'(i); step();
    end
    in_valid = 1'b0;
    check("mid_level_pre", 32'(level), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid),  32'd0);
    check("mid_rst_level", 32'(level),      32'd0);
    check("mid_rst_ready", 32'(in_ready),   32'd1);
    check("mid_rst_cnt",   32'(result_cnt), 32'd0);
    check("mid_rst_data",  32'(out_data),   32'd0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'h77; in_carry = 1'b0; in_sel = ALU_XOR;
    step();
    in_valid = 1'b0;
    check("post_rst_level", 32'(level),      32'd1);
    check("post_rst_data",  32'(out_data),   32'h77);
    check("post_rst_sel",   32'(out_sel),    32'hA);
    check("post_rst_cnt",   32'(result_cnt), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_rst_empty", 32'(out_valid), 32'd0);
`ifdef ALU_RES_PARITY_EN
    check("par_sticky", 32'(par_err_sticky), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 8-bit combinational ALU: captures each ALU result (ALU_Out, CarryOut, and the ALU_Sel that produced it) into a small FIFO.
- Presents results to a consumer over a valid/ready handshake and derives a zero flag.
- Keeps a saturating count of accepted results.
- Decouples the combinational ALU from a slower consumer (scoreboard, writeback stage).

Parameters:
- WIDTH, 8, data width of ALU_Out / buffered result
- SEL_W, 4, width of ALU_Sel tag stored with each result
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, 16, width of accepted-result counter

Ports:
- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has a result this cycle
- in_ready  out  1  buffer can accept (not full)
- in_data  in  WIDTH  ALU_Out
- in_carry  in  1  CarryOut
- in_sel  in  SEL_W  ALU_Sel that produced the result
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_data  out  WIDTH  head result
- out_carry  out  1  head carry
- out_sel  out  SEL_W  head opcode tag
- out_zero  out  1  head result == 0
- level  out  $clog2(DEPTH+1)  entries held
- result_cnt  out  CNT_W  accepted pushes, saturating

Behaviour:
- Reset (async assert, sync-released use): wr_ptr = rd_ptr = 0, level = 0, result_cnt = 0, in_ready = 1, out_valid = 0. out_data, out_carry, out_sel and out_zero read as 0 while empty.
- Push: in_valid && in_ready at the rising edge writes {in_sel, in_carry, in_data} at wr_ptr; wr_ptr++.
- Pop: out_valid && out_ready at the rising edge; rd_ptr++.
- in_ready = (level != DEPTH), combinational from registered state only. No dependency on out_ready: no pass-through when full.
- out_valid = (level != 0). Head fields are driven combinationally from mem[rd_ptr] and masked to 0 when empty.
- Latency: a result pushed into an empty buffer at edge N appears on out_* after edge N (1 cycle).
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, both pointers advance.
- Empty buffer: pop is impossible (out_valid = 0). A push alone makes level 1.
- Full buffer: push is impossible (in_ready = 0). A pop alone makes level DEPTH-1, and in_ready rises next cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level tracks fullness; no extra wrap bit is needed.
- out_zero = (out_data == 0) && out_valid. It ignores carry.
- result_cnt increments on every accepted push and holds at 2^CNT_W-1.
- Held data stability: while out_valid && !out_ready, out_* are stable.
- Upstream must hold in_* stable while in_valid && !in_ready. Violations are the upstream's fault; the buffer takes no action.
- Reset asserted mid-operation: all stored entries are discarded immediately. Outputs go to reset values asynchronously.

Optional Feature:
- Macro ALU_RES_PARITY_EN.
- Defined: each entry stores an even-parity bit computed over {in_sel, in_carry, in_data} at push. An extra output out_par_err (1 bit) = out_valid && (recomputed parity of head != stored parity). An extra output par_err_sticky (1 bit) sets on any popped entry with out_par_err, and clears only on reset.
- Undefined: no parity storage; ports out_par_err and par_err_sticky are absent.

Decomposition:
- Package alu_pkg:
  - localparams ALU_WIDTH = 8, ALU_SEL_W = 4.
  - typedef struct packed alu_res_t {sel, carry, data}.
  - ALU_Sel opcode enum, shared with the bench, including 4'b1011.
- Sub-module alu_res_mem: DEPTH x alu_res_t register array with one write port and one asynchronous read port, no reset on the storage.
- alu_result_buffer holds pointers, level, handshake, flags and counter.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> in_ready = 1, out_valid = 0, level = 0, result_cnt = 0, out_data = 0.
- Single result: push data 8'hA5, carry 1, sel 4'b1011, out_ready = 0 -> next cycle out_valid = 1, out_data = A5, out_carry = 1, out_sel = B, out_zero = 0, level = 1.
- Fill/overflow: push 8'h01..8'h05 back-to-back, out_ready = 0 -> 4 accepted, in_ready = 0 after the 4th, 05 held off, level = 4, result_cnt = 4. Then drain -> output order 01, 02, 03, 04.
- Concurrent: level = 2, push 8'h00 and pop in the same cycle -> level stays 2. When 00 reaches the head, out_zero = 1.
- Wrap: 10 push/pop pairs (data = i*3) at out_ready = 1 -> pointers wrap twice, outputs in order with 1-cycle latency, result_cnt = 10.
- Reset mid-operation: level = 3, assert rst_n between edges -> out_valid drops immediately, level = 0. After release, the first push appears alone.
